// File: rtl/sr_hart_pkg.sv
// Shared types and helpers for the multi-hart schoolRISCV scheduler.
package sr_hart_pkg;

    typedef enum logic [1:0] {
        StOff    = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } hart_state_e;

    localparam logic [31:0] DefaultResetPc      = 32'h0000_0000;
    localparam logic [31:0] DefaultHartPcStride = 32'h0000_0100;

    // Hart index width; never below one bit so single-bit selects stay legal.
    function automatic int unsigned hart_id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping modulo N.
module sr_rr_pick #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic         o_grant_valid,
    output logic [W-1:0] o_grant_idx
);

    logic [W-1:0] w_idx;

    // Scan from the farthest candidate back to last+1 so the nearest requester wins.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_idx         = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = W'((32'(i_last) + 32'(k)) % N);
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/sr_hart_scheduler.sv
// Per-hart PC/run-state owner and round-robin issue arbiter for the shared datapath.
// Define SR_HART_SCHED_STATS_EN to add per-hart retired-instruction counters.
module sr_hart_scheduler
    import sr_hart_pkg::*;
#(
    parameter int unsigned  NHARTS         = 2,
    parameter logic [31:0]  RESET_PC       = DefaultResetPc,
    parameter logic [31:0]  HART_PC_STRIDE = DefaultHartPcStride,
    localparam int unsigned HART_ID_W      = hart_id_w(NHARTS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NHARTS-1:0]    i_hart_en,
    input  logic [NHARTS-1:0]    i_hart_halt,
    input  logic [NHARTS-1:0]    i_hart_stall,
    input  logic                 i_commit,
    input  logic [31:0]          i_pc_next,
    output logic                 o_issue_valid,
    output logic [HART_ID_W-1:0] o_issue_hart,
    output logic [31:0]          o_issue_pc,
`ifdef SR_HART_SCHED_STATS_EN
    input  logic [HART_ID_W-1:0] i_stat_sel,
    output logic [31:0]          o_stat_count,
`endif
    output logic [NHARTS-1:0]    o_hart_running
);

    logic [NHARTS-1:0]         w_ready;
    logic [NHARTS-1:0]         w_running;
    logic [NHARTS-1:0][31:0]   w_pc;
    logic                      w_grant_valid;
    logic [HART_ID_W-1:0]      w_grant_idx;
    logic                      w_issue_valid;
    logic [HART_ID_W-1:0]      w_issue_hart;
    logic [31:0]               w_pc_aligned;

    logic [HART_ID_W-1:0]      r_last;
    logic                      r_locked;
    logic [HART_ID_W-1:0]      r_lock_hart;

    assign w_ready      = w_running & ~i_hart_stall;
    assign w_pc_aligned = i_pc_next & ~32'h0000_0003;

    sr_rr_pick #(
        .N (NHARTS),
        .W (HART_ID_W)
    ) u_pick (
        .i_req         (w_ready),
        .i_last        (r_last),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // A pending (uncommitted) issue pins the grant until the datapath retires it.
    assign w_issue_valid = r_locked | w_grant_valid;
    assign w_issue_hart  = r_locked ? r_lock_hart : w_grant_idx;

    assign o_issue_valid  = w_issue_valid;
    assign o_issue_hart   = w_issue_hart;
    assign o_issue_pc     = w_pc[w_issue_hart];
    assign o_hart_running = w_running;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last      <= HART_ID_W'(NHARTS - 1);
            r_locked    <= 1'b0;
            r_lock_hart <= '0;
        end else if (w_issue_valid) begin
            if (i_commit) begin
                r_last   <= w_issue_hart;
                r_locked <= 1'b0;
            end else begin
                r_locked    <= 1'b1;
                r_lock_hart <= w_issue_hart;
            end
        end
    end

`ifdef SR_HART_SCHED_STATS_EN
    logic [NHARTS-1:0][31:0] w_count;
    assign o_stat_count = w_count[i_stat_sel];
`endif

    for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart
        localparam logic [31:0] BootPc = RESET_PC + 32'(gi) * HART_PC_STRIDE;

        hart_state_e r_state;
        hart_state_e w_state_d;
        logic [31:0] r_pc;
        logic [31:0] w_pc_d;
        logic        r_halt_pend;
        logic        w_halt_pend_d;
        logic        w_sel;
        logic        w_retire;

        assign w_sel     = w_issue_valid && (w_issue_hart == HART_ID_W'(gi));
        assign w_retire  = w_sel && i_commit;
        assign w_pc[gi]      = r_pc;
        assign w_running[gi] = (r_state == StRun);

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_state     <= StOff;
                r_pc        <= BootPc;
                r_halt_pend <= 1'b0;
            end else begin
                r_state     <= w_state_d;
                r_pc        <= w_pc_d;
                r_halt_pend <= w_halt_pend_d;
            end
        end

        always_comb begin
            w_state_d     = r_state;
            w_pc_d        = r_pc;
            w_halt_pend_d = r_halt_pend;
            if (w_retire) begin
                w_pc_d        = w_pc_aligned;
                w_halt_pend_d = 1'b0;
            end
            case (r_state)
                StOff: begin
                    if (i_hart_halt[gi]) begin
                        w_state_d = StHalted;
                    end else if (i_hart_en[gi]) begin
                        w_state_d = StRun;
                    end
                end
                StRun: begin
                    // Halt of the in-flight hart takes effect on its commit edge.
                    if (w_sel) begin
                        if (w_retire && (i_hart_halt[gi] || r_halt_pend)) begin
                            w_state_d = StHalted;
                        end else if (!i_commit && i_hart_halt[gi]) begin
                            w_halt_pend_d = 1'b1;
                        end
                    end else if (i_hart_halt[gi]) begin
                        w_state_d = StHalted;
                    end
                end
                StHalted: begin
                    if (!i_hart_halt[gi] && i_hart_en[gi]) begin
                        w_state_d = StRun;
                    end
                end
                default: w_state_d = StOff;
            endcase
        end

`ifdef SR_HART_SCHED_STATS_EN
        logic [31:0] r_count;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_count <= '0;
            end else if (w_retire) begin
                r_count <= r_count + 32'd1;
            end
        end

        assign w_count[gi] = r_count;
`endif
    end

endmodule

// File: tb/tb_sr_hart_scheduler.sv
// Directed bench for sr_hart_scheduler (NHARTS=2) with an issue scoreboard.
module tb_sr_hart_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  hart_en = 2'b00;
    logic [1:0]  hart_halt = 2'b00;
    logic [1:0]  hart_stall = 2'b00;
    logic        commit = 1'b0;
    logic [31:0] pc_next = 32'h0;
    logic        issue_valid;
    logic [0:0]  issue_hart;
    logic [31:0] issue_pc;
    logic [1:0]  hart_running;
`ifdef SR_HART_SCHED_STATS_EN
    logic [0:0]  stat_sel = 1'b1;
    logic [31:0] stat_count;
`endif

    typedef struct packed {
        logic [0:0]  hart;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sr_hart_scheduler #(
        .NHARTS         (2),
        .RESET_PC       (32'h0),
        .HART_PC_STRIDE (32'h100)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hart_en      (hart_en),
        .i_hart_halt    (hart_halt),
        .i_hart_stall   (hart_stall),
        .i_commit       (commit),
        .i_pc_next      (pc_next),
        .o_issue_valid  (issue_valid),
        .o_issue_hart   (issue_hart),
        .o_issue_pc     (issue_pc),
`ifdef SR_HART_SCHED_STATS_EN
        .i_stat_sel     (stat_sel),
        .o_stat_count   (stat_count),
`endif
        .o_hart_running (hart_running)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [0:0] h, input logic [31:0] pc);
        sb.push_back(exp_t'{hart: h, pc: pc});
    endtask

    // Called at posedge+1: drive commit, compare at negedge, advance to next posedge+1.
    task automatic issue_step(input string tag, input logic c, input logic [31:0] nxt);
        exp_t e;
        commit  = c;
        pc_next = nxt;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
            chk({tag, "_hart"}, 32'(issue_hart), 32'(e.hart));
            chk({tag, "_pc"}, issue_pc, e.pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input string tag);
        commit = 1'b0;
        @(negedge clk);
        chk({tag, "_novalid"}, 32'(issue_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_running", 32'(hart_running), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle_step("pre_en");
        hart_en = 2'b11;
        idle_step("en_edge");
        chk("running_11", 32'(hart_running), 32'h3);

        // Strict rotation with commit every cycle
        push(1'b0, 32'h000); issue_step("rot0", 1'b1, 32'h004);
        push(1'b1, 32'h100); issue_step("rot1", 1'b1, 32'h104);
        push(1'b0, 32'h004); issue_step("rot2", 1'b1, 32'h008);
        push(1'b1, 32'h104); issue_step("rot3", 1'b1, 32'h108);

        // Lock on hart 0 while its stall rises
        push(1'b0, 32'h008); issue_step("lock0", 1'b0, 32'h0);
        hart_stall = 2'b01;
        push(1'b0, 32'h008); issue_step("lock1", 1'b0, 32'h0);
        push(1'b0, 32'h008); issue_step("lock2", 1'b0, 32'h0);
        push(1'b0, 32'h008); issue_step("lock_commit", 1'b1, 32'h00C);
        push(1'b1, 32'h108); issue_step("after_lock", 1'b1, 32'h10C);
        hart_stall = 2'b00;

        // Misaligned next-PC is forced to word alignment
        push(1'b0, 32'h00C); issue_step("misalign_wr", 1'b1, 32'h107);
        push(1'b1, 32'h10C); issue_step("misalign_h1", 1'b1, 32'h110);
        push(1'b0, 32'h104); issue_step("pc_align", 1'b1, 32'h108);

        // Halt hart 1 on its issuing commit, then resume
        hart_halt = 2'b10;
        hart_en   = 2'b01;
        push(1'b1, 32'h110); issue_step("halt_commit", 1'b1, 32'h200);
        hart_halt = 2'b00;
        chk("halted_running", 32'(hart_running), 32'h1);
        push(1'b0, 32'h108); issue_step("solo0", 1'b1, 32'h10C);
        chk("still_halted", 32'(hart_running), 32'h1);
        hart_en = 2'b11;
        push(1'b0, 32'h10C); issue_step("solo1", 1'b1, 32'h110);
        push(1'b1, 32'h200); issue_step("resume_pc", 1'b1, 32'h204);

        // Reset while locked on hart 1
        push(1'b0, 32'h110); issue_step("pre_lock", 1'b1, 32'h114);
        push(1'b1, 32'h204); issue_step("lock_h1", 1'b0, 32'h0);
        hart_stall = 2'b10;
        push(1'b1, 32'h204); issue_step("lock_h1_stall", 1'b0, 32'h0);
        commit  = 1'b1;
        pc_next = 32'h300;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(issue_valid), 32'd0);
        chk("midrst_running", 32'(hart_running), 32'd0);
`ifdef SR_HART_SCHED_STATS_EN
        chk("midrst_stat", stat_count, 32'd0);
`endif
        hart_stall = 2'b00;
        hart_halt  = 2'b01;
        hart_en    = 2'b11;
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // en+halt together from OFF: hart 0 goes HALTED, never runs
        chk("enhalt_running", 32'(hart_running), 32'h2);
        push(1'b1, 32'h100); issue_step("boot_pc1", 1'b1, 32'h104);
        push(1'b1, 32'h104); issue_step("h1_only", 1'b1, 32'h108);
        chk("enhalt_running2", 32'(hart_running), 32'h2);
        hart_halt = 2'b00;
        push(1'b1, 32'h108); issue_step("h1_last", 1'b1, 32'h10C);
        push(1'b0, 32'h000); issue_step("boot_pc0", 1'b1, 32'h004);
        push(1'b1, 32'h10C); issue_step("final_rot", 1'b1, 32'h110);

        // No ready hart
        hart_stall = 2'b11;
        idle_step("all_stalled");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sr_hart_scheduler.md
# sr_hart_scheduler

Hardware-thread scheduler for the multi-hart schoolRISCV core. Owns one program counter and one run-state machine per hart. Each cycle it picks the next ready hart round-robin and presents that hart's PC to instruction fetch and the shared decode/ALU/register-file datapath. It writes the datapath's next-PC back into the issuing hart's PC when the instruction commits. Sits between the fetch stage and the single-cycle datapath and replaces the single shared `pc` register.

## Interface
Parameters:
- `NHARTS`, 2: number of hardware threads (2..8).
- `RESET_PC`, 32'h0: boot PC of hart 0.
- `HART_PC_STRIDE`, 32'h100: boot PC of hart i is `RESET_PC + i*HART_PC_STRIDE`.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `hart_en` in NHARTS: start/resume request per hart, level.
- `hart_halt` in NHARTS: halt request per hart, level.
- `hart_stall` in NHARTS: hart not eligible for a new issue this cycle.
- `commit` in 1: datapath accepts and retires the issued instruction this cycle.
- `pc_next` in 32: next PC of the issued instruction, valid with `commit`.
- `issue_valid` out 1: an instruction slot is granted this cycle.
- `issue_hart` out $clog2(NHARTS): index of the granted hart.
- `issue_pc` out 32: PC of the granted hart.
- `hart_running` out NHARTS: per-hart state == RUN.

## Operation
- Per-hart FSM, states OFF, RUN and HALTED:
  - OFF→RUN on `hart_en[i]`. The PC keeps its boot value.
  - RUN→HALTED on `hart_halt[i]`.
  - HALTED→RUN on `hart_en[i]`. The hart resumes at its held PC.
  - `hart_en` and `hart_halt` asserted together: halt wins, and the hart stays in or enters HALTED. OFF with halt asserted goes to HALTED.
- Ready: `ready[i] = (state[i]==RUN) & ~hart_stall[i]`.
- Arbitration is round-robin from a registered pointer `last`. The grant is the first ready hart scanning `last+1, last+2, …` with wrap modulo NHARTS. No ready hart gives `issue_valid=0`, and `issue_hart`/`issue_pc` are don't-care.
- Lock rule: if `issue_valid & ~commit`, a `locked` flag sets. Grant, `issue_hart` and `issue_pc` are then frozen to that hart until `commit`, regardless of `hart_stall`, `hart_halt` or other harts' readiness.
- On `issue_valid & commit`:
  - `pc[issue_hart] <= {pc_next[31:2], 2'b00}`.
  - `last <= issue_hart`.
  - `locked` clears.
- `commit` without `issue_valid` is ignored.
- A halt requested for a hart that is locked or issuing is deferred: the state goes to HALTED on the edge where that instruction commits, after its PC update.
- Non-issuing harts' PCs never change.

## Timing
- Reset values:
  - All states OFF.
  - `pc[i] = RESET_PC + i*HART_PC_STRIDE`.
  - `last = NHARTS-1`, so hart 0 wins first.
  - `locked = 0`.
  - `issue_valid = 0`, `hart_running = 0`.
  - Stats counters (if built) = 0.
- `issue_*` outputs are combinational from registered state plus `hart_stall`. Zero-cycle issue latency, so the single-cycle datapath uses them in the same cycle.
- `hart_en` seen at edge N makes `hart_running[i]=1` and the hart issue-eligible in cycle N+1.
- Steady state with all harts ready and `commit=1` every cycle: strict rotation 0,1,…,NHARTS-1,0.
- `rst` asserted mid-operation, including while locked: immediate return to the reset values and the in-flight commit is dropped. First issue is possible in the first cycle after `rst` deasserts and `hart_en` is seen.

## Configuration
- `SR_HART_SCHED_STATS_EN` defined adds:
  - one 32-bit retired-instruction counter per hart, incremented on each `issue_valid & commit` for that hart and wrapping at 2^32;
  - port `stat_sel` in $clog2(NHARTS);
  - port `stat_count` out 32, a combinational read of `counter[stat_sel]`.
- Undefined: no counters and no `stat_*` ports. Scheduling behaviour is identical in both builds.

## Structure
- Shared package `sr_hart_pkg`:
  - hart state enum (OFF=2'd0, RUN=2'd1, HALTED=2'd2);
  - `HART_ID_W` derivation helper;
  - default `RESET_PC` and `HART_PC_STRIDE` constants.
- One sub-module, `sr_rr_pick`: combinational round-robin picker with inputs `req[NHARTS]` and `last` and outputs `grant_valid` and `grant_idx`. It is reusable for the data-memory port.
- Per-hart PC and FSM are held in generate loops inside `sr_hart_scheduler`.

## Test plan
- Reset, then `hart_en=2'b11` and `commit=1` each cycle with `pc_next=issue_pc+4`. Required `issue_hart` sequence: 0,1,0,1. Required `issue_pc`: 0x0, 0x100, 0x4, 0x104.
- Hart 0 issued with `commit=0` for 3 cycles while `hart_stall[0]` rises. Required: `issue_hart=0`, `issue_pc=0x8` held all 3 cycles, and hart 1 does not issue until after the commit.
- `hart_halt[1]` asserted while hart 1 is issuing with `pc_next=0x200`. Required: `pc[1]=0x200` and HALTED on the commit edge. On a later `hart_en[1]`, the first `issue_pc` for hart 1 is 0x200.
- `hart_en[0]` and `hart_halt[0]` asserted together from OFF. Required: `hart_running[0]=0` and hart 0 never issues.
- `rst` pulse while locked on hart 1. Required: `issue_valid=0` and all PCs at boot values. With `SR_HART_SCHED_STATS_EN` and `stat_sel=1`, `stat_count=0`.
- `pc_next=0x00000107` on commit. Required: the stored PC reads back 0x104.
